// File: rtl/vmul_issue_arbiter.sv
// Two-requester round-robin issue arbiter in front of a fixed-latency vector multiplier.
// Tracks per-requester credits and routes results back using an id tag pipeline.
module vmul_issue_arbiter #(
  parameter int REQ_DATA_WIDTH  = 64,
  parameter int REQ_ADDR_WIDTH  = 32,
  parameter int SEW_WIDTH       = 2,
  parameter int OPSEL_WIDTH     = 2,
  parameter int MUL_LATENCY     = 6,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req0_valid,
  output logic                        req0_ready,
  input  logic [REQ_DATA_WIDTH-1:0]   req0_vec0,
  input  logic [REQ_DATA_WIDTH-1:0]   req0_vec1,
  input  logic [SEW_WIDTH-1:0]        req0_sew,
  input  logic [OPSEL_WIDTH-1:0]      req0_opSel,
  input  logic                        req0_widen,
  input  logic                        req0_fxp,
  input  logic [REQ_ADDR_WIDTH-1:0]   req0_addr,
  input  logic                        req1_valid,
  output logic                        req1_ready,
  input  logic [REQ_DATA_WIDTH-1:0]   req1_vec0,
  input  logic [REQ_DATA_WIDTH-1:0]   req1_vec1,
  input  logic [SEW_WIDTH-1:0]        req1_sew,
  input  logic [OPSEL_WIDTH-1:0]      req1_opSel,
  input  logic                        req1_widen,
  input  logic                        req1_fxp,
  input  logic [REQ_ADDR_WIDTH-1:0]   req1_addr,
  output logic                        mul_in_valid,
  output logic [REQ_DATA_WIDTH-1:0]   mul_in_vec0,
  output logic [REQ_DATA_WIDTH-1:0]   mul_in_vec1,
  output logic [SEW_WIDTH-1:0]        mul_in_sew,
  output logic [OPSEL_WIDTH-1:0]      mul_in_opSel,
  output logic                        mul_in_widen,
  output logic                        mul_in_fxp,
  output logic [REQ_ADDR_WIDTH-1:0]   mul_in_addr,
  input  logic                        mul_out_valid,
  input  logic [REQ_DATA_WIDTH-1:0]   mul_out_vec,
  input  logic [REQ_ADDR_WIDTH-1:0]   mul_out_addr,
  input  logic [REQ_DATA_WIDTH/8-1:0] mul_out_vd,
  input  logic [REQ_DATA_WIDTH/8-1:0] mul_out_vd1,
  input  logic [REQ_DATA_WIDTH/8-1:0] mul_out_vd10,
  output logic [1:0]                  resp_valid,
  output logic [REQ_DATA_WIDTH-1:0]   resp_vec,
  output logic [REQ_ADDR_WIDTH-1:0]   resp_addr,
  output logic [REQ_DATA_WIDTH/8-1:0] resp_vd,
  output logic [REQ_DATA_WIDTH/8-1:0] resp_vd1,
  output logic [REQ_DATA_WIDTH/8-1:0] resp_vd10,
  output logic                        busy,
  output logic                        err
);

  localparam int CNT_W = 4;

  logic [CNT_W-1:0]          cnt0_r, cnt1_r;
  logic                      prio_r;
  logic                      elig0_s, elig1_s, grant0_s, grant1_s, grant_s;
  logic [REQ_DATA_WIDTH-1:0] sel_vec0_s, sel_vec1_s;
  logic [SEW_WIDTH-1:0]      sel_sew_s;
  logic [OPSEL_WIDTH-1:0]    sel_opsel_s;
  logic                      sel_widen_s, sel_fxp_s;
  logic [REQ_ADDR_WIDTH-1:0] sel_addr_s;
  logic                      mul_in_id_r;
  logic [MUL_LATENCY-1:0]    tag_v_r, tag_id_r;
  logic                      tag_out_v_s, tag_out_id_s;
  logic [1:0]                ret_r;

  // Eligibility and round-robin grant; prio_r names the requester that wins a tie.
  always_comb begin
    elig0_s  = (cnt0_r < CNT_W'(MAX_OUTSTANDING));
    elig1_s  = (cnt1_r < CNT_W'(MAX_OUTSTANDING));
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rst) begin
      grant0_s = 1'b0;
    end else if (req0_valid && elig0_s && req1_valid && elig1_s) begin
      grant0_s = ~prio_r;
      grant1_s = prio_r;
    end else if (req0_valid && elig0_s) begin
      grant0_s = 1'b1;
    end else if (req1_valid && elig1_s) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
    end
  end

  assign grant_s    = grant0_s | grant1_s;
  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Operand mux for the granted requester.
  always_comb begin
    if (grant1_s) begin
      sel_vec0_s  = req1_vec0;
      sel_vec1_s  = req1_vec1;
      sel_sew_s   = req1_sew;
      sel_opsel_s = req1_opSel;
      sel_widen_s = req1_widen;
      sel_fxp_s   = req1_fxp;
      sel_addr_s  = req1_addr;
    end else begin
      sel_vec0_s  = req0_vec0;
      sel_vec1_s  = req0_vec1;
      sel_sew_s   = req0_sew;
      sel_opsel_s = req0_opSel;
      sel_widen_s = req0_widen;
      sel_fxp_s   = req0_fxp;
      sel_addr_s  = req0_addr;
    end
  end

  // Multiplier issue register; fields are zeroed on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_in_valid <= 1'b0;
      mul_in_id_r  <= 1'b0;
      mul_in_vec0  <= '0;
      mul_in_vec1  <= '0;
      mul_in_sew   <= '0;
      mul_in_opSel <= '0;
      mul_in_widen <= 1'b0;
      mul_in_fxp   <= 1'b0;
      mul_in_addr  <= '0;
    end else if (grant_s) begin
      mul_in_valid <= 1'b1;
      mul_in_id_r  <= grant1_s;
      mul_in_vec0  <= sel_vec0_s;
      mul_in_vec1  <= sel_vec1_s;
      mul_in_sew   <= sel_sew_s;
      mul_in_opSel <= sel_opsel_s;
      mul_in_widen <= sel_widen_s;
      mul_in_fxp   <= sel_fxp_s;
      mul_in_addr  <= sel_addr_s;
    end else begin
      mul_in_valid <= 1'b0;
      mul_in_id_r  <= 1'b0;
      mul_in_vec0  <= '0;
      mul_in_vec1  <= '0;
      mul_in_sew   <= '0;
      mul_in_opSel <= '0;
      mul_in_widen <= 1'b0;
      mul_in_fxp   <= 1'b0;
      mul_in_addr  <= '0;
    end
  end

  // Tag pipeline: the last stage lines up with mul_out_valid for the same op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_r  <= '0;
      tag_id_r <= '0;
    end else begin
      tag_v_r[0]  <= mul_in_valid;
      tag_id_r[0] <= mul_in_id_r;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        tag_v_r[i]  <= tag_v_r[i-1];
        tag_id_r[i] <= tag_id_r[i-1];
      end
    end
  end

  assign tag_out_v_s  = tag_v_r[MUL_LATENCY-1];
  assign tag_out_id_s = tag_id_r[MUL_LATENCY-1];

  // Response register, credit-return pulse and sticky protocol error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 2'b00;
      resp_vec   <= '0;
      resp_addr  <= '0;
      resp_vd    <= '0;
      resp_vd1   <= '0;
      resp_vd10  <= '0;
      ret_r      <= 2'b00;
      err        <= 1'b0;
    end else begin
      if (mul_out_valid && tag_out_v_s) begin
        resp_valid <= tag_out_id_s ? 2'b10 : 2'b01;
        resp_vec   <= mul_out_vec;
        resp_addr  <= mul_out_addr;
        resp_vd    <= mul_out_vd;
        resp_vd1   <= mul_out_vd1;
        resp_vd10  <= mul_out_vd10;
      end else begin
        resp_valid <= 2'b00;
        resp_vec   <= '0;
        resp_addr  <= '0;
        resp_vd    <= '0;
        resp_vd1   <= '0;
        resp_vd10  <= '0;
      end
      // A lost result still returns its credit so the requester cannot starve.
      if (tag_out_v_s) begin
        ret_r <= tag_out_id_s ? 2'b10 : 2'b01;
      end else begin
        ret_r <= 2'b00;
      end
      if (mul_out_valid != tag_out_v_s) begin
        err <= 1'b1;
      end else begin
        err <= err;
      end
    end
  end

  // Outstanding counters and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_r <= '0;
      cnt1_r <= '0;
      prio_r <= 1'b0;
    end else begin
      case ({grant0_s, ret_r[0]})
        2'b10:   cnt0_r <= cnt0_r + CNT_W'(1);
        2'b01:   cnt0_r <= cnt0_r - CNT_W'(1);
        default: cnt0_r <= cnt0_r;
      endcase
      case ({grant1_s, ret_r[1]})
        2'b10:   cnt1_r <= cnt1_r + CNT_W'(1);
        2'b01:   cnt1_r <= cnt1_r - CNT_W'(1);
        default: cnt1_r <= cnt1_r;
      endcase
      if (grant0_s) begin
        prio_r <= 1'b1;
      end else if (grant1_s) begin
        prio_r <= 1'b0;
      end else begin
        prio_r <= prio_r;
      end
    end
  end

  assign busy = (cnt0_r != '0) | (cnt1_r != '0);

endmodule

// File: tb/tb_vmul_issue_arbiter.sv
// Randomized scoreboard bench for vmul_issue_arbiter with a behavioural multiplier
// and an arbitration/credit reference model.
module tb_vmul_issue_arbiter;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int VW = DW/8;
  localparam int LAT = 6;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_vec0, req0_vec1, req1_vec0, req1_vec1;
  logic [1:0] req0_sew, req0_opSel, req1_sew, req1_opSel;
  logic req0_widen, req0_fxp, req1_widen, req1_fxp;
  logic [AW-1:0] req0_addr, req1_addr;
  logic mul_in_valid;
  logic [DW-1:0] mul_in_vec0, mul_in_vec1;
  logic [1:0] mul_in_sew, mul_in_opSel;
  logic mul_in_widen, mul_in_fxp;
  logic [AW-1:0] mul_in_addr;
  logic mul_out_valid = 1'b0;
  logic [DW-1:0] mul_out_vec = '0;
  logic [AW-1:0] mul_out_addr = '0;
  logic [VW-1:0] mul_out_vd = '0, mul_out_vd1 = '0, mul_out_vd10 = '0;
  logic [1:0] resp_valid;
  logic [DW-1:0] resp_vec;
  logic [AW-1:0] resp_addr;
  logic [VW-1:0] resp_vd, resp_vd1, resp_vd10;
  logic busy, err;

  int n_tests = 0;
  int n_fail = 0;
  longint cyc = 0;
  logic inj = 1'b0;

  vmul_issue_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_vec0(req0_vec0), .req0_vec1(req0_vec1),
    .req0_sew(req0_sew), .req0_opSel(req0_opSel), .req0_widen(req0_widen), .req0_fxp(req0_fxp),
    .req0_addr(req0_addr),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_vec0(req1_vec0), .req1_vec1(req1_vec1),
    .req1_sew(req1_sew), .req1_opSel(req1_opSel), .req1_widen(req1_widen), .req1_fxp(req1_fxp),
    .req1_addr(req1_addr),
    .mul_in_valid(mul_in_valid), .mul_in_vec0(mul_in_vec0), .mul_in_vec1(mul_in_vec1),
    .mul_in_sew(mul_in_sew), .mul_in_opSel(mul_in_opSel), .mul_in_widen(mul_in_widen),
    .mul_in_fxp(mul_in_fxp), .mul_in_addr(mul_in_addr),
    .mul_out_valid(mul_out_valid), .mul_out_vec(mul_out_vec), .mul_out_addr(mul_out_addr),
    .mul_out_vd(mul_out_vd), .mul_out_vd1(mul_out_vd1), .mul_out_vd10(mul_out_vd10),
    .resp_valid(resp_valid), .resp_vec(resp_vec), .resp_addr(resp_addr),
    .resp_vd(resp_vd), .resp_vd1(resp_vd1), .resp_vd10(resp_vd10),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural multiplier: result appears LAT cycles after the issue cycle.
  logic          p_v[LAT];
  logic [DW-1:0] p_vec[LAT];
  logic [AW-1:0] p_addr[LAT];
  logic [VW-1:0] p_vd[LAT], p_vd1[LAT], p_vd10[LAT];
  initial for (int i = 0; i < LAT; i++) p_v[i] = 1'b0;
  always @(negedge clk) begin
    mul_out_valid = p_v[LAT-1] | inj;
    mul_out_vec   = p_vec[LAT-1];
    mul_out_addr  = p_addr[LAT-1];
    mul_out_vd    = p_vd[LAT-1];
    mul_out_vd1   = p_vd1[LAT-1];
    mul_out_vd10  = p_vd10[LAT-1];
    for (int i = LAT-1; i > 0; i--) begin
      p_v[i] = p_v[i-1]; p_vec[i] = p_vec[i-1]; p_addr[i] = p_addr[i-1];
      p_vd[i] = p_vd[i-1]; p_vd1[i] = p_vd1[i-1]; p_vd10[i] = p_vd10[i-1];
    end
    p_v[0]    = mul_in_valid;
    p_vec[0]  = mul_in_vec0 * mul_in_vec1;
    p_addr[0] = mul_in_addr;
    p_vd[0]   = mul_in_vec0[7:0] + mul_in_vec1[7:0];
    p_vd1[0]  = mul_in_addr[7:0];
    p_vd10[0] = {mul_in_fxp, mul_in_widen, mul_in_opSel, mul_in_sew, 2'b00};
  end

  // Reference model: per-requester credit counts, tie-break pointer, in-order in-flight list.
  typedef struct { int id; logic [DW-1:0] vec; logic [AW-1:0] addr; logic [VW-1:0] vd, vd1, vd10; longint due; } exp_t;
  exp_t sb[$];
  exp_t infl[$];
  int cnt[2];
  int prio;

  function automatic exp_t make_exp(input int g);
    exp_t e;
    logic [DW-1:0] a, b;
    e.id = g;
    a = (g == 0) ? req0_vec0 : req1_vec0;
    b = (g == 0) ? req0_vec1 : req1_vec1;
    e.vec  = a * b;
    e.addr = (g == 0) ? req0_addr : req1_addr;
    e.vd   = a[7:0] + b[7:0];
    e.vd1  = e.addr[7:0];
    e.vd10 = (g == 0) ? {req0_fxp, req0_widen, req0_opSel, req0_sew, 2'b00}
                      : {req1_fxp, req1_widen, req1_opSel, req1_sew, 2'b00};
    e.due  = cyc + LAT + 2;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      cnt[0] = 0; cnt[1] = 0; prio = 0; infl.delete();
    end else begin
      int g;
      bit e0, e1;
      exp_t e;
      while (infl.size() > 0 && infl[0].due < cyc) begin
        cnt[infl[0].id]--;
        void'(infl.pop_front());
      end
      e0 = req0_valid && (cnt[0] < MAXO);
      e1 = req1_valid && (cnt[1] < MAXO);
      g = -1;
      if (e0 && e1) g = prio;
      else if (e0) g = 0;
      else if (e1) g = 1;
      chk("busy", busy, (cnt[0] != 0 || cnt[1] != 0));
      chk("ready", {req1_ready, req0_ready}, (g < 0) ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01));
      if (g >= 0) begin
        e = make_exp(g);
        infl.push_back(e);
        sb.push_back(e);
        cnt[g]++;
        prio = (g == 0) ? 1 : 0;
      end
    end
  end

  // Monitor: compare every presented response against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else if (resp_valid != 2'b00) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", resp_valid, 2'b00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_id", resp_valid, (e.id == 1) ? 2'b10 : 2'b01);
        chk("resp_vec", resp_vec, e.vec);
        chk("resp_addr", resp_addr, e.addr);
        chk("resp_vd", resp_vd, e.vd);
        chk("resp_vd1", resp_vd1, e.vd1);
        chk("resp_vd10", resp_vd10, e.vd10);
        chk("resp_cycle", cyc, e.due);
      end
    end else begin
      chk("resp_idle_zero", resp_vec | resp_addr | resp_vd | resp_vd1 | resp_vd10, 64'd0);
    end
  end

  task automatic set_req(input int n, input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [AW-1:0] ad);
    if (n == 0) begin
      req0_valid = v; req0_vec0 = a; req0_vec1 = b; req0_addr = ad;
      req0_sew = 2'($urandom); req0_opSel = 2'($urandom);
      req0_widen = 1'($urandom); req0_fxp = 1'($urandom);
    end else begin
      req1_valid = v; req1_vec0 = a; req1_vec1 = b; req1_addr = ad;
      req1_sew = 2'($urandom); req1_opSel = 2'($urandom);
      req1_widen = 1'($urandom); req1_fxp = 1'($urandom);
    end
  endtask

  task automatic rand_req(input int n, input bit v);
    set_req(n, v, {$urandom, $urandom}, {$urandom, $urandom}, $urandom);
  endtask

  task automatic idle();
    rand_req(0, 1'b0);
    rand_req(1, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 200) begin
      step();
      k++;
    end
    chk("drain_timeout", (k < 200), 1'b1);
    repeat (3) step();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_mul_in", {mul_in_valid, mul_in_vec0 | mul_in_vec1}, 0);
    chk("rst_resp", resp_valid, 2'b00);
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
    repeat (2) step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (8) step();
    rst = 1'b0;
    chk("reset_busy", busy, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_mul_in_valid", mul_in_valid, 1'b0);

    // Single operation: 3*5 to address 0x10.
    step();
    set_req(0, 1'b1, 64'd3, 64'd5, 32'h10);
    step();
    idle();
    chk("single_mul_in_valid", mul_in_valid, 1'b1);
    chk("single_mul_in_vec0", mul_in_vec0, 64'd3);
    chk("single_mul_in_addr", mul_in_addr, 32'h10);
    drain();

    // Contention: both requesters valid for 6 cycles.
    for (int i = 0; i < 6; i++) begin
      rand_req(0, 1'b1);
      rand_req(1, 1'b1);
      step();
    end
    idle();
    drain();

    // Credit limit: req1 alone, continuously valid.
    for (int i = 0; i < 20; i++) begin
      rand_req(1, 1'b1);
      step();
    end
    idle();
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_req(0, ($urandom_range(0, 99) < 60));
      rand_req(1, ($urandom_range(0, 99) < 45));
      step();
    end
    idle();
    drain();
    chk("err_clean", err, 1'b0);

    // Reset with three ops in flight; late results must flag err.
    for (int i = 0; i < 3; i++) begin
      rand_req(0, 1'b1);
      step();
    end
    idle();
    repeat (2) step();
    rand_req(0, 1'b1);
    pulse_rst();
    idle();
    repeat (10) step();
    chk("late_result_err", err, 1'b1);
    rand_req(1, 1'b1);
    step();
    idle();
    drain();

    // Spurious multiplier result with nothing issued.
    pulse_rst();
    repeat (10) step();
    chk("pre_spurious_err", err, 1'b0);
    inj = 1'b1;
    step();
    inj = 1'b0;
    repeat (2) step();
    chk("spurious_err", err, 1'b1);
    chk("spurious_resp", resp_valid, 2'b00);
    repeat (5) step();
    chk("err_sticky", err, 1'b1);
    pulse_rst();
    step();
    chk("err_cleared", err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vmul_issue_arbiter.md
VMUL_ISSUE_ARBITER -- requirements
Module: vmul_issue_arbiter

Interface
REQ-001 SHALL have parameter REQ_DATA_WIDTH, default 64, operand/result width in bits.
REQ-002 SHALL have parameter REQ_ADDR_WIDTH, default 32, destination address width.
REQ-003 SHALL have parameters SEW_WIDTH and OPSEL_WIDTH, default 2 each, element-width and op-select field widths.
REQ-004 SHALL have parameter MUL_LATENCY, default 6, fixed cycles from mul_in_valid to mul_out_valid.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4, per-requester in-flight limit (1..15).
REQ-006 SHALL have ports:
- clk  in  1  sole clock; rising edge.
- rst  in  1  reset; asynchronous, active-high.
- reqN_valid  in  1  requester N (N=0,1) has an op.
- reqN_ready  out  1  requester N op accepted this cycle.
- reqN_vec0, reqN_vec1  in  REQ_DATA_WIDTH  operands.
- reqN_sew  in  SEW_WIDTH; reqN_opSel  in  OPSEL_WIDTH; reqN_widen, reqN_fxp  in  1; reqN_addr  in  REQ_ADDR_WIDTH.
- mul_in_valid  out  1; mul_in_vec0, mul_in_vec1, mul_in_sew, mul_in_opSel, mul_in_widen, mul_in_fxp, mul_in_addr  out  matching widths; drive the multiplier.
- mul_out_valid  in  1; mul_out_vec  in  REQ_DATA_WIDTH; mul_out_addr  in  REQ_ADDR_WIDTH; mul_out_vd, mul_out_vd1, mul_out_vd10  in  REQ_DATA_WIDTH/8; multiplier results.
- resp_valid  out  2  one-hot, bit N = result for requester N.
- resp_vec, resp_addr, resp_vd, resp_vd1, resp_vd10  out  widths as mul_out_*  shared response bus.
- busy  out  1  any op in flight.
- err  out  1  sticky protocol error.

Function
REQ-007 SHALL grant at most one requester per cycle; reqN_ready high only for the granted requester, and only when reqN_valid high.
REQ-008 Requester N eligible SHALL require outstanding_N < MAX_OUTSTANDING.
REQ-009 Arbitration SHALL be round-robin: both eligible+valid -> grant the one not granted last; single eligible+valid -> grant it; after reset, req0 has priority.
REQ-010 reqN_ready SHALL be combinational from valid, eligibility and round-robin pointer; pointer updates only on a grant.
REQ-011 On grant at cycle t, mul_in_* SHALL carry the granted fields with mul_in_valid=1 at t+1 (registered); with no grant, mul_in_valid=0 and mul_in_* data fields zero.
REQ-012 SHALL keep a MUL_LATENCY-deep tag shift register of {valid, id}, loaded from mul_in_valid and granted id, shifting every cycle.
REQ-013 When mul_out_valid=1, the tag at the output stage SHALL supply id; resp_valid[id]=1 and resp_* = mul_out_* one cycle later (registered).
REQ-014 End-to-end latency grant->resp_valid SHALL be MUL_LATENCY+2 cycles (8 at default); back-to-back grants yield back-to-back responses in order.
REQ-015 outstanding_N SHALL increment on grant to N, decrement on resp_valid[N]; simultaneous increment and decrement -> unchanged.
REQ-016 mul_out_valid=1 with tag output stage invalid SHALL set err and produce no resp_valid; tag valid with mul_out_valid=0 SHALL set err and decrement that requester's count (result lost).
REQ-017 When resp_valid=0, resp_* data fields SHALL be zero.
REQ-018 busy SHALL equal (outstanding_0 != 0) | (outstanding_1 != 0).
REQ-019 err SHALL stay set until reset.

Reset
REQ-020 rst high SHALL immediately clear: reqN_ready, mul_in_*, resp_valid, resp_*, busy, err, tag register, outstanding counters; round-robin pointer -> req0 priority.
REQ-021 Reset mid-operation SHALL discard all in-flight tags; late mul_out_valid arriving within MUL_LATENCY cycles after reset release SHALL set err.

Verification
REQ-022 Single op: req0 valid, vec0=3, vec1=5, addr=0x10 at cycle 0 -> req0_ready cycle 0, mul_in_valid cycle 1, resp_valid=2'b01, resp_addr=0x10 at cycle 8 (model returns 15).
REQ-023 Contention: req0 and req1 valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; responses return in same order.
REQ-024 Credit limit: req1 valid continuously, no req0 -> exactly 4 grants, req1_ready low until first resp_valid[1], then one grant the next cycle.
REQ-025 Spurious result: mul_out_valid pulsed with no op issued -> err=1, resp_valid stays 0, err held until rst.
REQ-026 Reset mid-flight: 3 ops issued, rst pulsed 2 cycles later -> outputs zero instantly, busy=0; post-reset single op completes normally with correct id.
